// File: rtl/execute_hazard_controller_pkg.sv
//============================================================================
// Package     : exec_hazard_pkg
// Description : Shared types for the Execute-stage hazard controller:
//               forward-select encoding, the pipeline slot record and the
//               hazard FSM state encoding, plus a slot/operand match helper.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package exec_hazard_pkg;

  // Register index width carried in every slot. The top-level
  // REG_ADDR_WIDTH parameter defaults to this value and must track it.
  localparam int SLOT_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                       valid;
    logic [SLOT_ADDR_WIDTH-1:0] src1;
    logic [SLOT_ADDR_WIDTH-1:0] src2;
    logic                       src1_vec;
    logic                       src2_vec;
    logic                       use_src2;
    logic [SLOT_ADDR_WIDTH-1:0] dst;
    logic                       dst_vec;
    logic                       reg_write;
    logic                       mem_read;
  } slot_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam slot_t EMPTY_SLOT = '0;

  // True when slot s will write register idx of the given kind.
  function automatic logic slot_writes(input slot_t s,
                                       input logic [SLOT_ADDR_WIDTH-1:0] idx,
                                       input logic is_vec);
    return s.valid && s.reg_write && (s.dst == idx) && (s.dst_vec == is_vec);
  endfunction

endpackage

`default_nettype wire

// File: rtl/execute_hazard_controller_fwd_select.sv
//============================================================================
// Module      : fwd_select
// Description : Chooses the source of one Execute operand. Compares the
//               operand against the M and WB slots; M wins because it holds
//               the newer value.
// Ports       : m_slot, wb_slot - registered M / WB pipeline slots
//               idx, is_vec     - operand register index and kind
//               used            - operand is really read and belongs to the
//                                 register file this selector steers
//               sel             - FWD_M / FWD_WB / FWD_REG
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module fwd_select
  import exec_hazard_pkg::*;
(
  input  slot_t                      m_slot,
  input  slot_t                      wb_slot,
  input  logic [SLOT_ADDR_WIDTH-1:0] idx,
  input  logic                       is_vec,
  input  logic                       used,
  output fwd_sel_t                   sel
);

  // Scalar r0 is hard-wired, so it never takes a forwarded value.
  logic eligible;
  assign eligible = used && (is_vec || (idx != '0));

  always_comb begin
    sel = FWD_REG;
    if (eligible && slot_writes(m_slot, idx, is_vec)) begin
      sel = FWD_M;
    end else if (eligible && slot_writes(wb_slot, idx, is_vec)) begin
      sel = FWD_WB;
    end
  end

  // Source-side fields of the slots play no part in forwarding.
  logic unused_fields;
  assign unused_fields = ^{m_slot.src1, m_slot.src2, m_slot.src1_vec,
                           m_slot.src2_vec, m_slot.use_src2, m_slot.mem_read,
                           wb_slot.src1, wb_slot.src2, wb_slot.src1_vec,
                           wb_slot.src2_vec, wb_slot.use_src2, wb_slot.mem_read};

endmodule

`default_nettype wire

// File: rtl/execute_hazard_controller.sv
//============================================================================
// Module      : execute_hazard_controller
// Description : Tracks in-flight destinations for EX, M and WB, drives the
//               four Execute forward selectors, and steers the pipeline
//               registers on load-use hazards, memory waits and flushes.
// Ports       : clk, rst_n            - clock, async active-low reset
//               id_*                  - decoded fields of the ID instruction
//               flush                 - discard the ID instruction
//               mem_ready             - memory finishes the M access now
//               data{1,2}{Scalar,Vector}ForwardSelector - EX operand source
//               stall_fetch           - hold PC and IF/ID
//               bubble_ex             - load a NOP into ID/EX
//               freeze_all            - hold ID/EX, EX/M and M/WB
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module execute_hazard_controller
  import exec_hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = SLOT_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_src1,
  input  logic [REG_ADDR_WIDTH-1:0] id_src2,
  input  logic                      id_src1_vec,
  input  logic                      id_src2_vec,
  input  logic                      id_use_src2,
  input  logic [REG_ADDR_WIDTH-1:0] id_dst,
  input  logic                      id_dst_vec,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      flush,
  input  logic                      mem_ready,
  output logic [1:0]                data1ScalarForwardSelector,
  output logic [1:0]                data2ScalarForwardSelector,
  output logic [1:0]                data1VectorForwardSelector,
  output logic [1:0]                data2VectorForwardSelector,
  output logic                      stall_fetch,
  output logic                      bubble_ex,
  output logic                      freeze_all
);

  slot_t     ex_slot, m_slot, wb_slot;
  slot_t     id_slot;
  hz_state_t state, state_next;
  logic      load_use;
  logic      m_load_pending;
  logic      freeze;
  logic      bubble;

  //--------------------------------------------------------------------------
  // Slot image of the instruction in ID
  //--------------------------------------------------------------------------
  always_comb begin
    id_slot           = EMPTY_SLOT;
    id_slot.valid     = id_valid && !flush;
    id_slot.src1      = SLOT_ADDR_WIDTH'(id_src1);
    id_slot.src2      = SLOT_ADDR_WIDTH'(id_src2);
    id_slot.src1_vec  = id_src1_vec;
    id_slot.src2_vec  = id_src2_vec;
    id_slot.use_src2  = id_use_src2;
    id_slot.dst       = SLOT_ADDR_WIDTH'(id_dst);
    id_slot.dst_vec   = id_dst_vec;
    id_slot.reg_write = id_reg_write;
    id_slot.mem_read  = id_mem_read;
  end

  //--------------------------------------------------------------------------
  // Hazard detection
  //--------------------------------------------------------------------------
  // A load in EX whose result an ID source needs cannot be forwarded in
  // time; one bubble lets it reach WB before the consumer enters EX.
  assign load_use = id_valid && ex_slot.mem_read &&
                    (slot_writes(ex_slot, id_slot.src1, id_src1_vec) ||
                     (id_use_src2 && slot_writes(ex_slot, id_slot.src2, id_src2_vec)));

  assign m_load_pending = m_slot.valid && m_slot.mem_read && !mem_ready;

  // The hazard response is applied in the cycle the condition is seen so the
  // consumer is held in ID; state records which response is in progress.
  always_comb begin
    freeze     = 1'b0;
    state_next = RUN;
    case (state)
      MEM_WAIT: freeze = !mem_ready;  // the stalled load is still in M
      default:  freeze = m_load_pending;
    endcase
    // Freeze outranks everything; a flushed ID needs no bubble.
    bubble = !freeze && !flush && load_use;
    if (freeze) begin
      state_next = MEM_WAIT;
    end else if (bubble) begin
      state_next = BUBBLE;
    end
  end

  //--------------------------------------------------------------------------
  // Slot pipeline and state
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      ex_slot <= EMPTY_SLOT;
      m_slot  <= EMPTY_SLOT;
      wb_slot <= EMPTY_SLOT;
    end else begin
      state <= state_next;
      if (!freeze) begin
        wb_slot <= m_slot;
        m_slot  <= ex_slot;
        ex_slot <= bubble ? EMPTY_SLOT : id_slot;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Forward selectors: each register file only sees operands of its kind
  //--------------------------------------------------------------------------
  fwd_sel_t sel_s1, sel_s2, sel_v1, sel_v2;

  fwd_select u_fwd_s1 (
    .m_slot (m_slot),
    .wb_slot(wb_slot),
    .idx    (ex_slot.src1),
    .is_vec (1'b0),
    .used   (!ex_slot.src1_vec),
    .sel    (sel_s1)
  );

  fwd_select u_fwd_s2 (
    .m_slot (m_slot),
    .wb_slot(wb_slot),
    .idx    (ex_slot.src2),
    .is_vec (1'b0),
    .used   (ex_slot.use_src2 && !ex_slot.src2_vec),
    .sel    (sel_s2)
  );

  fwd_select u_fwd_v1 (
    .m_slot (m_slot),
    .wb_slot(wb_slot),
    .idx    (ex_slot.src1),
    .is_vec (1'b1),
    .used   (ex_slot.src1_vec),
    .sel    (sel_v1)
  );

  fwd_select u_fwd_v2 (
    .m_slot (m_slot),
    .wb_slot(wb_slot),
    .idx    (ex_slot.src2),
    .is_vec (1'b1),
    .used   (ex_slot.use_src2 && ex_slot.src2_vec),
    .sel    (sel_v2)
  );

  assign data1ScalarForwardSelector = sel_s1;
  assign data2ScalarForwardSelector = sel_s2;
  assign data1VectorForwardSelector = sel_v1;
  assign data2VectorForwardSelector = sel_v2;

  assign stall_fetch = freeze || bubble;
  assign bubble_ex   = bubble;
  assign freeze_all  = freeze;

endmodule

`default_nettype wire
